// File: rtl/down_counter_reload_pkg.sv
// Shared constants for the reloadable down counter: default width and
// the encodings of the auto-reload mode select.
package down_counter_reload_pkg;

  localparam int   WIDTH_DEFAULT = 4;
  localparam logic MODE_WRAP     = 1'b0;
  localparam logic MODE_RELOAD   = 1'b1;

endpackage : down_counter_reload_pkg

// File: rtl/down_counter_reload.sv
// Cascadable synchronous down counter with parallel load, a hidden reload
// register, a registered terminal-event pulse and a combinational borrow-out.
module down_counter_reload
  import down_counter_reload_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             CP,
  input  logic             Rd,
  input  logic             LD,
  input  logic             EP,
  input  logic             ET,
  input  logic             AR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             B,
  output logic             Z
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             z_q, z_d;
  logic             count_en;
  logic             at_zero;

  assign count_en = EP & ET;
  assign at_zero  = (q_q == '0);

  // NOTE: every output of this block is given a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    q_d = q_q;
    r_d = r_q;
    z_d = 1'b0;
    if (!LD) begin
      q_d = D;
      r_d = D;
    end else if (count_en) begin
      if (!at_zero) begin
        q_d = q_q - ONE;
      end else begin
        // Terminal count: either reload the preset or wrap to all-ones.
        z_d = 1'b1;
        q_d = (AR == MODE_RELOAD) ? r_q : '1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge CP or negedge Rd) begin
    if (!Rd) begin
      q_q <= '0;
      r_q <= '0;
      z_q <= 1'b0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      z_q <= z_d;
    end
  end

  // Borrow must ripple through a cascade within one cycle, so it stays
  // combinational and follows an asynchronous reset immediately.
  assign B = ET & at_zero;
  assign Q = q_q;
  assign Z = z_q;

endmodule : down_counter_reload

// File: doc/down_counter_reload.md
DOWN_COUNTER_RELOAD -- requirements
Module: down_counter_reload

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and data width in bits (legal 2..16).
REQ-002 SHALL have port CP  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port Rd  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port LD  input  1  synchronous load, active-low.
REQ-005 SHALL have port EP  input  1  count enable (parallel), active-high.
REQ-006 SHALL have port ET  input  1  count enable (trickle), active-high; also gates B.
REQ-007 SHALL have port AR  input  1  auto-reload mode select: 1 reload, 0 free wrap.
REQ-008 SHALL have port D  input  WIDTH  preset value.
REQ-009 SHALL have port Q  output  WIDTH  counter value, registered.
REQ-010 SHALL have port B  output  1  borrow-out for cascading, combinational.
REQ-011 SHALL have port Z  output  1  terminal-event pulse, registered.

Function
REQ-012 SHALL hold internal reload register R (WIDTH bits), not visible on ports.
REQ-013 SHALL apply priority per edge: Rd low > LD low > count (EP&ET) > hold.
REQ-014 LD low SHALL load Q<=D and R<=D on the edge, regardless of EP/ET/AR; Z<=0.
REQ-015 Count cycle (LD high, EP=ET=1) with Q!=0 SHALL set Q<=Q-1, Z<=0.
REQ-016 Count cycle with Q==0 and AR=0 SHALL wrap Q<=all-ones (2^WIDTH-1) and set Z<=1.
REQ-017 Count cycle with Q==0 and AR=1 SHALL set Q<=R and Z<=1.
REQ-018 AR=1 with R==0 SHALL keep Q at 0 and pulse Z=1 on every count cycle.
REQ-019 Hold cycle (LD high, EP&ET=0) SHALL keep Q and R; Z<=0.
REQ-020 Z SHALL be high for exactly one cycle per terminal event, latency one edge after the count cycle that saw Q==0.
REQ-021 B SHALL equal ET AND (Q==0), independent of EP, CP and AR, no registering.
REQ-022 Cascading: B of a lower stage drives ET of the next stage; the pair SHALL count down as one 2*WIDTH-bit counter with common CP, EP, LD.
REQ-023 AR change SHALL take effect on the next count cycle at Q==0, no other side effect.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH; no other wrap path exists.

Reset
REQ-025 Rd low SHALL immediately force Q=0, R=0, Z=0, independent of CP.
REQ-026 Rd low mid-count SHALL abort the count; B SHALL follow Q==0 at once (B=ET).
REQ-027 On Rd release, first rising CP edge SHALL obey REQ-013 normally; no dead cycle.

Structure
REQ-028 Shared package SHALL hold the WIDTH default and the AR mode constants (MODE_WRAP=0, MODE_RELOAD=1); no typedefs needed.
REQ-029 SHALL be a single module, no sub-modules; the two-stage cascade exists only in the bench.

Verification
REQ-030 Rd=0 while Q=9 mid-count -> Q=0, Z=0, B=ET without clock edge; release, EP=ET=1, AR=0 -> next edge Q=15, Z=1 next cycle.
REQ-031 LD=0, D=5, AR=1, then 6 count cycles -> Q: 5,4,3,2,1,0,5; Z high one cycle after Q=0 count; B high only while Q=0 and ET=1.
REQ-032 LD=0 and EP=ET=1 same edge, D=3, Q=7 -> Q=3 (load wins), Z=0.
REQ-033 EP=0, ET=1, Q=0 held 4 cycles -> Q stays 0, B=1, Z=0; ET=0 -> B=0.
REQ-034 AR=1, LD with D=0, 3 count cycles -> Q stays 0, Z=1 each following cycle.
REQ-035 Two WIDTH=4 instances cascaded, load 0x10, count 2 cycles -> 0x0F then 0x0E; load 0x00, AR=0, 1 count -> 0xFF.
